// File: rtl/led_mode_controller.sv
// Push-button LED mode controller: synchronised press-down detect with lockout,
// four-mode sequencer (OFF/ON/SLOW/FAST) and blink generator driving the LED.
//
// state     | meaning
// MODE_OFF  | LED dark
// MODE_ON   | LED steadily lit
// MODE_SLOW | LED blinks, SLOW_HALF_PERIOD cycles per level
// MODE_FAST | LED blinks, FAST_HALF_PERIOD cycles per level
module led_mode_controller #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int SLOW_HALF_PERIOD = 25000000,
  parameter int FAST_HALF_PERIOD = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_n,
  output logic       led,
  output logic [1:0] mode,
  output logic       press_pulse
);

  localparam int LW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXH = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ? SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
  localparam int BW   = $clog2(MAXH + 1);

  localparam logic [LW-1:0] LOCK_LOAD = LW'(DEBOUNCE_CYCLES);
  localparam logic [BW-1:0] SLOW_TC   = BW'(SLOW_HALF_PERIOD - 1);
  localparam logic [BW-1:0] FAST_TC   = BW'(FAST_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  mode_t         state_q, state_d;
  logic          s1, s2, prev;
  logic [LW-1:0] lockout;
  logic [BW-1:0] bcnt, bcnt_d;
  logic          blink, blink_d;
  logic          led_d;
  logic          press_det;

  assign press_det = prev & ~s2 & (lockout == '0);
  assign mode      = state_q;

  // Synchroniser resets to "pressed" so a button held through reset is not a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      prev        <= 1'b0;
      lockout     <= '0;
      state_q     <= MODE_OFF;
      bcnt        <= '0;
      blink       <= 1'b0;
      led         <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      s1          <= button_n;
      s2          <= s1;
      prev        <= s2;
      if (press_det)
        lockout <= LOCK_LOAD;
      else if (lockout != '0)
        lockout <= lockout - LW'(1);
      state_q     <= state_d;
      bcnt        <= bcnt_d;
      blink       <= blink_d;
      led         <= led_d;
      press_pulse <= press_det;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt;
    blink_d = blink;
    led_d   = 1'b0;

    if (press_det) begin
      case (state_q)
        MODE_OFF:  state_d = MODE_ON;
        MODE_ON:   state_d = MODE_SLOW;
        MODE_SLOW: state_d = MODE_FAST;
        default:   state_d = MODE_OFF;
      endcase
      // Every accepted press restarts the blink phase lit.
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else begin
      case (state_q)
        MODE_SLOW: begin
          if (bcnt == SLOW_TC) begin
            bcnt_d  = '0;
            blink_d = ~blink;
          end else begin
            bcnt_d = bcnt + BW'(1);
          end
        end
        MODE_FAST: begin
          if (bcnt == FAST_TC) begin
            bcnt_d  = '0;
            blink_d = ~blink;
          end else begin
            bcnt_d = bcnt + BW'(1);
          end
        end
        default: bcnt_d = '0;
      endcase
    end

    case (state_d)
      MODE_OFF: led_d = 1'b0;
      MODE_ON:  led_d = 1'b1;
      default:  led_d = blink_d;
    endcase
  end

endmodule

// File: tb/tb_led_mode_controller.sv
// Scoreboard bench for led_mode_controller: a press/lockout/blink reference model
// queues expected outputs per edge; a monitor pops and compares after each edge.
module tb_led_mode_controller;

  localparam int DEB   = 4;
  localparam int SLOWH = 6;
  localparam int FASTH = 2;
  localparam int NCYC  = 4096;

  logic       clock = 1'b0;
  logic       reset;
  logic       button_n;
  logic       led;
  logic [1:0] mode;
  logic       press_pulse;

  led_mode_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .SLOW_HALF_PERIOD(SLOWH),
    .FAST_HALF_PERIOD(FASTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button_n   (button_n),
    .led        (led),
    .mode       (mode),
    .press_pulse(press_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       led;
    logic [1:0] mode;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: history of what the input stage holds after each edge.
  bit v_h[NCYC];
  bit r_h[NCYC];
  int t_now     = 0;
  int m_mode    = 0;
  int last_acc  = -1000;
  int entry_t   = 0;

  task automatic model_edge(input bit r, input bit b);
    exp_t e;
    int   o;
    bit   fall;
    o      = t_now;
    r_h[o] = r;
    v_h[o] = r ? 1'b0 : b;
    e.pulse = 1'b0;
    if (r) begin
      m_mode   = 0;
      last_acc = -1000;
    end else begin
      // Falling edge first sampled at edge o-2 reaches the outputs at edge o.
      fall = (o >= 3) && v_h[o-3] && !v_h[o-2] && !r_h[o-2] && !r_h[o-1];
      if (fall && (o - last_acc >= DEB + 1)) begin
        m_mode   = (m_mode + 1) % 4;
        last_acc = o;
        entry_t  = o;
        e.pulse  = 1'b1;
        pulse_q.push_back(m_mode);
      end
    end
    e.mode = 2'(m_mode);
    case (m_mode)
      0:       e.led = 1'b0;
      1:       e.led = 1'b1;
      2:       e.led = (((o - entry_t) / SLOWH) % 2) == 0;
      default: e.led = (((o - entry_t) / FASTH) % 2) == 0;
    endcase
    exp_q.push_back(e);
    t_now++;
  endtask

  task automatic step(input bit r, input bit b);
    reset    = r;
    button_n = b;
    model_edge(r, b);
    @(negedge clock);
  endtask

  task automatic steps(input int n, input bit r, input bit b);
    for (int i = 0; i < n; i++) step(r, b);
  endtask

  always @(posedge clock) begin
    exp_t e;
    int   pm;
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL exp_queue_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      compared++;
      if (led !== e.led) begin
        mismatched++;
        $display("FAIL led at %0t: got %b expected %b", $time, led, e.led);
      end
      compared++;
      if (mode !== e.mode) begin
        mismatched++;
        $display("FAIL mode at %0t: got %0d expected %0d", $time, mode, e.mode);
      end
      compared++;
      if (press_pulse !== e.pulse) begin
        mismatched++;
        $display("FAIL press_pulse at %0t: got %b expected %b", $time, press_pulse, e.pulse);
      end
    end
    if (press_pulse === 1'b1) begin
      compared++;
      if (pulse_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse at %0t: mode %0d, no press expected", $time, mode);
      end else begin
        pm = pulse_q.pop_front();
        if (mode !== 2'(pm)) begin
          mismatched++;
          $display("FAIL pulse_mode at %0t: got %0d expected %0d", $time, mode, pm);
        end
      end
    end
  end

  initial begin
    bit lvl;
    // reset, then idle
    steps(3, 1, 1);
    steps(6, 0, 1);
    // mode walk with blink observation
    for (int p = 0; p < 4; p++) begin
      steps(10, 0, 0);
      steps(10, 0, 1);
    end
    // into SLOW, watch blink, then FAST
    steps(5, 0, 0);
    steps(10, 0, 1);
    steps(5, 0, 0);
    steps(20, 0, 1);
    steps(5, 0, 0);
    steps(12, 0, 1);
    // bounce after an accepted press
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    steps(10, 0, 1);
    // press reaching s2 exactly when lockout expires
    step(0, 0);
    steps(3, 0, 1);
    step(0, 0);
    steps(10, 0, 1);
    // held through reset
    steps(3, 0, 0);
    steps(3, 1, 0);
    steps(8, 0, 0);
    steps(6, 0, 1);
    steps(6, 0, 0);
    steps(8, 0, 1);
    // reach SLOW, then reset on the edge a press would land
    steps(6, 0, 0);
    steps(8, 0, 1);
    steps(2, 0, 0);
    steps(2, 1, 0);
    steps(6, 0, 1);
    steps(6, 0, 0);
    steps(8, 0, 1);
    // randomized phase
    lvl = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      if ($urandom_range(0, 299) == 0) begin
        step(1, lvl);
        step(1, lvl);
      end else begin
        step(0, lvl);
      end
    end
    steps(10, 0, 1);
    #2;
    compared++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      mismatched++;
      $display("FAIL queues_drained: exp %0d pulse %0d left, expected 0", exp_q.size(), pulse_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
